// File: rtl/h2f_evt_pkg.sv
// Shared widths and the packed event record for the HPS-to-FPGA register event streamer.
package h2f_evt_pkg;

  localparam int TOTREG_DEF     = 32;
  localparam int DATAWIDTH_DEF  = 64;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam int IDXW = $clog2(TOTREG_DEF);
  localparam int EVTW = IDXW + DATAWIDTH_DEF;

  typedef struct packed {
    logic [IDXW-1:0]          idx;
    logic [DATAWIDTH_DEF-1:0] data;
  } evt_t;

endpackage

// File: rtl/h2f_reg_event_streamer_if.sv
// Bank read port plus event stream of the register event streamer.
interface h2f_reg_event_streamer_if
  import h2f_evt_pkg::*;
#(
  parameter int IW = IDXW,
  parameter int DW = DATAWIDTH_DEF
);

  logic [IW-1:0] regsel_o;
  logic [DW-1:0] regdata_i;

  // Event stream: a beat transfers on a rising clk edge where evt_valid_o and
  // evt_ready_i are both high; while valid is high and ready low, idx/data hold.
  logic          evt_valid_o;
  logic          evt_ready_i;
  logic [IW-1:0] evt_idx_o;
  logic [DW-1:0] evt_data_o;

  modport master (
    output regsel_o, evt_valid_o, evt_idx_o, evt_data_o,
    input  regdata_i, evt_ready_i
  );

  modport slave (
    input  regsel_o, evt_valid_o, evt_idx_o, evt_data_o,
    output regdata_i, evt_ready_i
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/level status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_data    = r_mem[r_rd];
  // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

endmodule

// File: rtl/h2f_reg_event_streamer.sv
// Scans the HPS-to-FPGA register bank round-robin against a shadow copy and
// streams {index, data} events for changed registers or for a full resync dump.
module h2f_reg_event_streamer
  import h2f_evt_pkg::*;
#(
  parameter int TOTREG     = TOTREG_DEF,
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic                          resync_i,
  h2f_reg_event_streamer_if.master      bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          scan_wrap_o,
  output logic                          dump_busy_o
);

  localparam int L_IDXW = $clog2(TOTREG);
  localparam int L_EVTW = L_IDXW + DATAWIDTH;

  logic [L_IDXW-1:0]    r_idx;
  logic [DATAWIDTH-1:0] r_shadow [TOTREG];
  logic                 r_dump;

  logic                 w_last;
  logic                 w_need;
  logic                 w_push;
  logic                 w_adv;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic [L_EVTW-1:0]    w_fifo_out;

  assign w_last = (r_idx == L_IDXW'(TOTREG - 1));
  assign w_need = enable_i & ((bus.regdata_i != r_shadow[r_idx]) | r_dump);
  // A resync cycle neither pushes nor advances: the dump that follows revisits everything.
  assign w_push = w_need & ~w_full & ~resync_i;
  assign w_adv  = enable_i & (~w_need | ~w_full) & ~resync_i;

  assign scan_wrap_o = w_adv & w_last & ~rst;
  assign dump_busy_o = r_dump;
  assign bus.regsel_o = r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_dump <= 1'b0;
      for (int i = 0; i < TOTREG; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      if (resync_i) begin
        r_idx  <= '0;
        r_dump <= 1'b1;
      end else begin
        if (w_adv) begin
          r_idx <= r_idx + 1'b1;
        end
        if (w_push && r_dump && w_last) begin
          r_dump <= 1'b0;
        end
      end
      if (w_push) begin
        r_shadow[r_idx] <= bus.regdata_i;
      end
    end
  end

  assign w_pop = ~w_empty & bus.evt_ready_i;

  sync_fifo #(
    .WIDTH (L_EVTW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_idx, bus.regdata_i}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level_o)
  );

  assign bus.evt_valid_o = ~w_empty;
  assign bus.evt_idx_o   = w_fifo_out[L_EVTW-1 -: L_IDXW];
  assign bus.evt_data_o  = w_fifo_out[DATAWIDTH-1:0];

endmodule

// File: tb/tb_h2f_reg_event_streamer.sv
// Bench for h2f_reg_event_streamer: random bank writes checked against a shadow/event model.
module tb_h2f_reg_event_streamer;
  import h2f_evt_pkg::*;

  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst;
  logic enable_i;
  logic resync_i;
  logic [3:0] fifo_level_o;
  logic scan_wrap_o;
  logic dump_busy_o;

  logic [63:0] bank [NREG];
  logic [63:0] model_shadow [NREG];
  logic [EVTW-1:0] exp_q[$];
  logic [EVTW-1:0] obs_q[$];

  int checks = 0;
  int failures = 0;

  h2f_reg_event_streamer_if bus ();
  assign bus.regdata_i = bank[bus.regsel_o];

  h2f_reg_event_streamer dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .resync_i     (resync_i),
    .bus          (bus),
    .fifo_level_o (fifo_level_o),
    .scan_wrap_o  (scan_wrap_o),
    .dump_busy_o  (dump_busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits up to budget cycles for one accepted event; ready optionally randomised.
  task automatic get_event(input int budget, input bit rnd,
                           output logic [EVTW-1:0] ev, output bit ok);
    ok = 1'b0;
    ev = '0;
    for (int c = 0; c < budget; c++) begin
      bus.evt_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.evt_valid_o === 1'b1 && bus.evt_ready_i === 1'b1) begin
        ev = {bus.evt_idx_o, bus.evt_data_o};
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    bus.evt_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable_i = 1'b0;
    resync_i = 1'b0;
    bus.evt_ready_i = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      bank[i] = '0;
      model_shadow[i] = '0;
    end
    repeat (3) tick();
    checks++; if (bus.regsel_o !== 5'd0) begin failures++; $display("FAIL reset_regsel got=%0d exp=0", bus.regsel_o); end
    checks++; if (bus.evt_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.evt_valid_o); end
    checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level_o); end
    checks++; if (scan_wrap_o !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", scan_wrap_o); end
    checks++; if (dump_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dump_busy_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_scan();
    int wraps[$];
    bit saw_valid;
    saw_valid = 1'b0;
    enable_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (bus.evt_valid_o !== 1'b0) saw_valid = 1'b1;
      if (scan_wrap_o === 1'b1) wraps.push_back(k);
      tick();
    end
    checks++; if (saw_valid) begin failures++; $display("FAIL idle_no_event got=valid exp=none"); end
    checks++; if (wraps.size() != 3) begin failures++; $display("FAIL idle_wrap_count got=%0d exp=3", wraps.size()); end
    if (wraps.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (wraps[j] != 31 + 32 * j) begin
          failures++; $display("FAIL idle_wrap_pos[%0d] got=%0d exp=%0d", j, wraps[j], 31 + 32 * j);
        end
      end
    end
  endtask

  task automatic test_single_change();
    logic [EVTW-1:0] ev;
    evt_t e;
    bit ok;
    bit saw_valid;
    bank[5] = 64'hDEAD_BEEF;
    get_event(33, 1'b0, ev, ok);
    e = ev;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_timeout got=no_event exp=event_within_33");
    end else if (e.idx !== 5'd5 || e.data !== 64'hDEAD_BEEF) begin
      failures++; $display("FAIL single_event got=%0d/%h exp=5/%h", e.idx, e.data, 64'hDEAD_BEEF);
    end
    model_shadow[5] = 64'hDEAD_BEEF;
    saw_valid = 1'b0;
    bus.evt_ready_i = 1'b1;
    for (int k = 0; k < 70; k++) begin
      #1; if (bus.evt_valid_o !== 1'b0) saw_valid = 1'b1;
      tick();
    end
    bus.evt_ready_i = 1'b0;
    checks++; if (saw_valid) begin failures++; $display("FAIL single_no_repeat got=valid exp=none"); end
  endtask

  task automatic test_random_changes();
    bit pend [NREG];
    logic [63:0] want [NREG];
    logic [EVTW-1:0] ev;
    evt_t e;
    bit ok;
    bit saw_valid;
    int n_exp;
    for (int round = 0; round < 4; round++) begin
      n_exp = 0;
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        bank[$urandom_range(0, NREG - 1)] = {$urandom(), $urandom()};
      end
      for (int i = 0; i < NREG; i++) begin
        pend[i] = (bank[i] !== model_shadow[i]);
        want[i] = bank[i];
        if (pend[i]) n_exp++;
      end
      for (int k = 0; k < n_exp; k++) begin
        get_event(200, 1'b1, ev, ok);
        e = ev;
        checks++;
        if (!ok) begin
          failures++; $display("FAIL rand_timeout round=%0d got=%0d events exp=%0d", round, k, n_exp);
          break;
        end
        if (!pend[e.idx] || e.data !== want[e.idx]) begin
          failures++; $display("FAIL rand_event round=%0d got=%0d/%h exp=%h pending=%b", round, e.idx, e.data, want[e.idx], pend[e.idx]);
        end else begin
          pend[e.idx] = 1'b0;
          model_shadow[e.idx] = e.data;
        end
      end
      saw_valid = 1'b0;
      bus.evt_ready_i = 1'b1;
      for (int k = 0; k < 40; k++) begin
        #1; if (bus.evt_valid_o !== 1'b0) saw_valid = 1'b1;
        tick();
      end
      bus.evt_ready_i = 1'b0;
      checks++; if (saw_valid) begin failures++; $display("FAIL rand_extra round=%0d got=valid exp=none", round); end
      for (int i = 0; i < NREG; i++) model_shadow[i] = bank[i];
    end
  endtask

  task automatic test_backpressure();
    logic [EVTW-1:0] ev;
    logic [EVTW-1:0] held;
    logic [EVTW-1:0] want;
    bit ok;
    bit found;
    found = 1'b0;
    bus.evt_ready_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.regsel_o === 5'd0) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL bp_sync got=no_index0 exp=index0"); end
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      bank[i] = {$urandom(), $urandom()};
      if (bank[i] === model_shadow[i]) bank[i] = ~bank[i];
      exp_q.push_back({5'(i), bank[i]});
    end
    repeat (40) tick();
    checks++; if (fifo_level_o !== 4'd8) begin failures++; $display("FAIL bp_level got=%0d exp=8", fifo_level_o); end
    checks++; if (bus.regsel_o !== 5'd8) begin failures++; $display("FAIL bp_regsel got=%0d exp=8", bus.regsel_o); end
    checks++; if (bus.evt_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", bus.evt_valid_o); end
    held = {bus.evt_idx_o, bus.evt_data_o};
    repeat (3) tick();
    checks++; if ({bus.evt_idx_o, bus.evt_data_o} !== held) begin failures++; $display("FAIL bp_stable got=%h exp=%h", {bus.evt_idx_o, bus.evt_data_o}, held); end
    for (int k = 0; k < 10; k++) begin
      get_event(100, 1'b1, ev, ok);
      want = exp_q.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL bp_timeout got=%0d events exp=10", k);
        break;
      end
      if (ev !== want) begin
        failures++; $display("FAIL bp_event[%0d] got=%h exp=%h", k, ev, want);
      end
    end
    for (int i = 0; i < 10; i++) model_shadow[i] = bank[i];
  endtask

  task automatic test_resync_dump();
    logic [EVTW-1:0] ev;
    logic [EVTW-1:0] want;
    bit ok;
    exp_q.delete();
    for (int i = 0; i < NREG; i++) begin
      bank[i] = 64'(i);
      exp_q.push_back({5'(i), 64'(i)});
    end
    resync_i = 1'b1;
    tick();
    resync_i = 1'b0;
    checks++; if (dump_busy_o !== 1'b1) begin failures++; $display("FAIL dump_busy_start got=%b exp=1", dump_busy_o); end
    for (int k = 0; k < NREG; k++) begin
      get_event(200, 1'b1, ev, ok);
      want = exp_q.pop_front();
      checks++;
      if (!ok) begin
        failures++; $display("FAIL dump_timeout got=%0d events exp=32", k);
        break;
      end
      if (ev !== want) begin
        failures++; $display("FAIL dump_event[%0d] got=%h exp=%h", k, ev, want);
      end
    end
    checks++; if (dump_busy_o !== 1'b0) begin failures++; $display("FAIL dump_busy_end got=%b exp=0", dump_busy_o); end
    for (int i = 0; i < NREG; i++) model_shadow[i] = bank[i];
  endtask

  task automatic test_resync_restart();
    logic [EVTW-1:0] want;
    bit pulsed;
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back({5'(i), model_shadow[i]});
    for (int i = 0; i < NREG; i++) exp_q.push_back({5'(i), model_shadow[i]});
    pulsed = 1'b0;
    bus.evt_ready_i = 1'b1;
    resync_i = 1'b1;
    tick();
    for (int c = 0; c < 300 && obs_q.size() < 44; c++) begin
      resync_i = 1'b0;
      if (!pulsed && bus.regsel_o === 5'd12) begin
        resync_i = 1'b1;
        pulsed = 1'b1;
      end
      if (bus.evt_valid_o === 1'b1) obs_q.push_back({bus.evt_idx_o, bus.evt_data_o});
      tick();
    end
    resync_i = 1'b0;
    repeat (4) tick();
    bus.evt_ready_i = 1'b0;
    checks++; if (!pulsed) begin failures++; $display("FAIL restart_reach12 got=not_reached exp=reached"); end
    checks++; if (obs_q.size() != 44) begin failures++; $display("FAIL restart_count got=%0d exp=44", obs_q.size()); end
    for (int k = 0; k < 44 && k < obs_q.size(); k++) begin
      want = exp_q[k];
      checks++;
      if (obs_q[k] !== want) begin
        failures++; $display("FAIL restart_event[%0d] got=%h exp=%h", k, obs_q[k], want);
      end
    end
    checks++; if (dump_busy_o !== 1'b0) begin failures++; $display("FAIL restart_busy_end got=%b exp=0", dump_busy_o); end
    checks++; if (bus.evt_valid_o !== 1'b0) begin failures++; $display("FAIL restart_extra got=%b exp=0", bus.evt_valid_o); end
  endtask

  task automatic test_reset_mid_pass();
    bit reached;
    reached = 1'b0;
    bus.evt_ready_i = 1'b0;
    resync_i = 1'b1;
    tick();
    resync_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (fifo_level_o === 4'd4) begin reached = 1'b1; break; end
      tick();
    end
    checks++; if (!reached) begin failures++; $display("FAIL midrst_level4 got=%0d exp=4", fifo_level_o); end
    checks++; if (dump_busy_o !== 1'b1) begin failures++; $display("FAIL midrst_busy_pre got=%b exp=1", dump_busy_o); end
    rst = 1'b1;
    tick();
    checks++; if (fifo_level_o !== 4'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", fifo_level_o); end
    checks++; if (bus.evt_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.evt_valid_o); end
    checks++; if (bus.regsel_o !== 5'd0) begin failures++; $display("FAIL midrst_regsel got=%0d exp=0", bus.regsel_o); end
    checks++; if (dump_busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", dump_busy_o); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_change();
    test_random_changes();
    test_backpressure();
    test_resync_dump();
    test_resync_restart();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/h2f_reg_event_streamer.md
Name: h2f_reg_event_streamer

Overview:
- Sits directly downstream of the HPS-to-FPGA register bank, on its fabric_regsel/fabric_regdata read port.
- Scans all TOTREG bank registers round-robin and keeps a shadow copy of each.
- Emits an {index, data} event on a valid/ready stream whenever a register changes, or for every register during a software-triggered resync pass.
- Lets fabric logic react to HPS writes without polling or decoding the Avalon bus.

Parameters:
TOTREG, 32, number of bank registers scanned; power of two, >=2
DATAWIDTH, 64, register data width
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable_i  in  1  scan enable; 0 freezes the scan index, FIFO pop still works
resync_i  in  1  one-cycle pulse; restarts the scan at index 0 and forces a full dump pass
regsel_o  out  $clog2(TOTREG)  register select to bank (fabric_regsel_i)
regdata_i  in  DATAWIDTH  register data from bank (fabric_regdata_o), combinational from regsel_o
evt_valid_o  out  1  event available
evt_ready_i  in  1  consumer accepts event
evt_idx_o  out  $clog2(TOTREG)  event register index
evt_data_o  out  DATAWIDTH  event register value
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
scan_wrap_o  out  1  one-cycle pulse when the scan index advances from TOTREG-1 to 0
dump_busy_o  out  1  high while a resync dump pass is active

Behaviour:
Reset:
- regsel_o = 0, all shadow entries = 0 (matches bank reset data), FIFO empty.
- evt_valid_o = 0, fifo_level_o = 0, scan_wrap_o = 0, dump_busy_o = 0.
Scan:
- regsel_o is a registered index idx. regdata_i is valid in the same cycle as idx.
- Each cycle with enable_i=1, compare regdata_i against shadow[idx].
- An event is required if regdata_i != shadow[idx] or dump_busy_o=1.
- Event required and FIFO not full: push {idx, regdata_i}, set shadow[idx] <= regdata_i, then idx <= idx+1 (wraps modulo TOTREG).
- Event required and FIFO full: stall. idx, shadow and dump state hold. No event is ever dropped.
- No event required: idx advances.
- scan_wrap_o pulses in the cycle idx advances from TOTREG-1 to 0.
Resync:
- resync_i sets dump_busy_o=1 and idx <= 0 next cycle, overriding any advance or stall in that cycle.
- resync_i while dump_busy_o=1 restarts the pass at 0.
- dump_busy_o clears in the cycle after index TOTREG-1 is pushed during the dump.
- resync_i is honoured even when enable_i=0; the dump proceeds once enabled.
FIFO:
- First-word fall-through.
- A pushed entry appears on evt_* the cycle after the push (latency 1 from compare to evt_valid_o).
- Pop when evt_valid_o & evt_ready_i. evt_idx_o/evt_data_o are stable while valid and not ready.
- Push is gated on !full, evaluated before the same-cycle pop. Simultaneous push and pop when not full leaves the level unchanged.
- fifo_level_o reflects the registered count.
Other rules:
- A register changing twice between visits yields one event carrying the latest value. This coalescing is intended.
- rst asserted mid-pass aborts the dump and clears the FIFO. Events lost here are acceptable.

Decomposition:
- Package h2f_evt_pkg: typedef evt_t as a packed struct {idx, data}, and the localparams IDXW = $clog2(TOTREG) and EVTW.
- Sub-module sync_fifo, parameterised WIDTH/DEPTH, FWFT, with full/empty/level outputs.
- Shadow storage is a flop array in the top level, so a reset-clear is available.

Test Plan:
- Reset, bank all zero, enable_i=1 for 100 cycles -> evt_valid_o never asserts; scan_wrap_o pulses every 32 cycles.
- Bank reg 5 set to 64'hDEAD_BEEF -> exactly one event with idx=5, data=64'hDEAD_BEEF, within 33 cycles; no repeat on later passes.
- evt_ready_i=0, change regs 0..9 -> FIFO fills to 8 and regsel_o stalls at 8. Raise ready -> 10 events in index order, none lost, values match.
- resync_i pulse with bank reg i = i -> 32 events idx 0..31 with data i. dump_busy_o is high for the pass and clears after idx 31 is pushed.
- resync_i re-pulsed at idx 12 of a dump -> the pass restarts at 0; events 0..11 appear twice in total, the dump ends after idx 31.
- rst asserted with FIFO level 4 and dump active -> next cycle level=0, evt_valid_o=0, regsel_o=0, dump_busy_o=0.
